// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Row drive patterns, FSM states and column priority decode.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] ROW_DRIVE [0:3] = '{
        4'b1110,
        4'b1101,
        4'b1011,
        4'b0111
    };

    // Lowest-indexed low column wins; all-high returns 0 and is
    // never used as a decision on its own.
    function automatic logic [1:0] lowest_low(input logic [3:0] cs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cs[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer with an all-ones reset value, sized by W.
// Used on the active-low keypad columns so reset reads as idle.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: row strobe, debounce, key code output
// and a four-nibble history register for the display driver.
module keypad4x4_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 14,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digit
);

    localparam int CW = $clog2(DEBOUNCE_SCANS);
    // Decision is made on the tick that moves cnt to DEBOUNCE_SCANS-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 2);

    logic [SCAN_DIV_BITS-1:0] prescaler;
    logic                     tick;
    logic [3:0]               cs;
    logic                     cs_idle;
    logic [1:0]               low_idx;
    logic                     still_low;

    state_t        state, state_n;
    logic [1:0]    row_idx, row_idx_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n;
    logic          key_held_n;
    logic [15:0]   digit_n;

    keypad_sync #(
        .W(4)
    ) u_col_sync (
        .clk(clk),
        .rst(rst),
        .d  (col),
        .q  (cs)
    );

    assign tick      = &prescaler;
    assign cs_idle   = (cs == 4'hF);
    assign low_idx   = lowest_low(cs);
    assign still_low = !cs[col_idx] && (low_idx == col_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            cnt       <= '0;
            row       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            digit     <= 16'h0000;
        end else begin
            prescaler <= prescaler + 1'b1;
            state     <= state_n;
            row_idx   <= row_idx_n;
            col_idx   <= col_idx_n;
            cnt       <= cnt_n;
            row       <= ROW_DRIVE[row_idx_n];
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
            digit     <= digit_n;
        end
    end

    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        col_idx_n   = col_idx;
        cnt_n       = cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        digit_n     = digit;

        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (cs_idle) begin
                        row_idx_n = row_idx + 2'd1;
                    end else begin
                        col_idx_n = low_idx;
                        cnt_n     = '0;
                        state_n   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (still_low) begin
                        cnt_n = cnt + CW'(1);
                        if (cnt == CNT_LAST) begin
                            state_n     = PRESSED;
                            key_code_n  = {row_idx, col_idx};
                            key_valid_n = 1'b1;
                            digit_n     = {digit[11:0], row_idx, col_idx};
                        end
                    end else begin
                        state_n   = SCAN;
                        row_idx_n = row_idx + 2'd1;
                    end
                end
                PRESSED: begin
                    if (cs_idle) begin
                        cnt_n   = '0;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!cs_idle) begin
                        cnt_n = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n   = SCAN;
                        row_idx_n = row_idx + 2'd1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            endcase
        end

        key_held_n = (state_n == PRESSED) || (state_n == RELEASE);
    end

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Directed bench for keypad4x4_scan with a row-aware keypad model.
// One tick every 8 clk, four matching ticks to accept or release.
module tb_keypad4x4_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digit;

    logic       pressed = 1'b0;
    logic [1:0] prow = 2'd0;
    logic [3:0] ppat = 4'hF;
    logic [2:0] pc = 3'd0;
    int         vcount = 0;
    int         total = 0;
    int         bad = 0;

    logic [3:0] rowpat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad4x4_scan #(
        .SCAN_DIV_BITS (3),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .digit    (digit)
    );

    always #5 clk = ~clk;

    // Pressed key shows on the columns only while its row is driven.
    assign col = (pressed && row === rowpat[prow]) ? ppat : 4'hF;

    always @(posedge clk) pc <= rst ? 3'd0 : pc + 3'd1;

    always @(negedge clk) if (key_valid === 1'b1) vcount <= vcount + 1;

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            while (pc != 3'd7) @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_target(input logic [1:0] r);
        int n;
        n = 0;
        while (!(row === rowpat[r] && pc == 3'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_row%0d timeout row=%b", r, row);
        end
    endtask

    task automatic do_press(input logic [1:0] r, input logic [3:0] p,
                            input int hold);
        wait_target(r);
        prow    = r;
        ppat    = p;
        pressed = 1'b1;
        wait_ticks(hold);
        pressed = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        pressed = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (row !== 4'b1110) begin
            bad++; $display("FAIL reset_row got=%b exp=1110", row);
        end
        total++;
        if (key_code !== 4'h0) begin
            bad++; $display("FAIL reset_code got=%h exp=0", key_code);
        end
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", key_valid);
        end
        total++;
        if (key_held !== 1'b0) begin
            bad++; $display("FAIL reset_held got=%b exp=0", key_held);
        end
        total++;
        if (digit !== 16'h0000) begin
            bad++; $display("FAIL reset_digit got=%h exp=0000", digit);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            total++;
            if (row !== rowpat[(k / 8) % 4]) begin
                bad++;
                $display("FAIL idle_row clk%0d got=%b exp=%b",
                         k, row, rowpat[(k / 8) % 4]);
            end
            total++;
            if (key_valid !== 1'b0) begin
                bad++; $display("FAIL idle_valid clk%0d got=%b exp=0", k, key_valid);
            end
        end
    endtask

    task automatic test_single_press;
        int v0;
        v0 = vcount;
        wait_target(2);
        prow    = 2;
        ppat    = 4'b1101;
        pressed = 1'b1;
        wait_ticks(3);
        total++;
        if (key_valid !== 1'b0 || row !== 4'b1011) begin
            bad++;
            $display("FAIL press_early got valid=%b row=%b exp valid=0 row=1011",
                     key_valid, row);
        end
        wait_ticks(1);
        total++;
        if (key_valid !== 1'b1) begin
            bad++; $display("FAIL press_valid got=%b exp=1", key_valid);
        end
        total++;
        if (key_code !== 4'h9) begin
            bad++; $display("FAIL press_code got=%h exp=9", key_code);
        end
        total++;
        if (digit !== 16'h0009) begin
            bad++; $display("FAIL press_digit got=%h exp=0009", digit);
        end
        total++;
        if (key_held !== 1'b1) begin
            bad++; $display("FAIL press_held got=%b exp=1", key_held);
        end
        @(negedge clk);
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL press_pulse_width got=%b exp=0", key_valid);
        end
        wait_ticks(2);
        pressed = 1'b0;
        wait_ticks(3);
        total++;
        if (key_held !== 1'b1 || row !== 4'b1011) begin
            bad++;
            $display("FAIL release_early got held=%b row=%b exp held=1 row=1011",
                     key_held, row);
        end
        wait_ticks(1);
        total++;
        if (key_held !== 1'b0 || row !== 4'b0111) begin
            bad++;
            $display("FAIL release_done got held=%b row=%b exp held=0 row=0111",
                     key_held, row);
        end
        total++;
        if (vcount - v0 !== 1) begin
            bad++; $display("FAIL press_count got=%0d exp=1", vcount - v0);
        end
    endtask

    task automatic test_bounce;
        logic [1:0] r;
        logic [3:0] p;
        int v0;
        for (int n = 2; n <= 3; n++) begin
            r  = (n == 2) ? 2'd3 : 2'd0;
            p  = (n == 2) ? 4'b1110 : 4'b1011;
            v0 = vcount;
            wait_target(r);
            prow    = r;
            ppat    = p;
            pressed = 1'b1;
            wait_ticks(n);
            total++;
            if (row !== rowpat[r] || key_held !== 1'b0) begin
                bad++;
                $display("FAIL bounce%0d_frozen got row=%b held=%b exp row=%b held=0",
                         n, row, key_held, rowpat[r]);
            end
            pressed = 1'b0;
            wait_ticks(1);
            total++;
            if (row !== rowpat[r + 2'd1] || key_held !== 1'b0) begin
                bad++;
                $display("FAIL bounce%0d_resume got row=%b held=%b exp row=%b held=0",
                         n, row, key_held, rowpat[r + 2'd1]);
            end
            total++;
            if (vcount !== v0) begin
                bad++; $display("FAIL bounce%0d_count got=%0d exp=%0d", n, vcount, v0);
            end
        end
    endtask

    task automatic test_sequence;
        int v0;
        v0 = vcount;
        do_press(2'd0, 4'b1101, 4);
        do_press(2'd0, 4'b1011, 20);
        do_press(2'd0, 4'b0111, 4);
        do_press(2'd1, 4'b1110, 4);
        total++;
        if (vcount - v0 !== 4) begin
            bad++; $display("FAIL seq_count got=%0d exp=4", vcount - v0);
        end
        total++;
        if (digit !== 16'h1234) begin
            bad++; $display("FAIL seq_digit got=%h exp=1234", digit);
        end
        total++;
        if (key_code !== 4'h4) begin
            bad++; $display("FAIL seq_code got=%h exp=4", key_code);
        end
    endtask

    task automatic test_priority_reset;
        int v1;
        wait_target(1);
        prow    = 1;
        ppat    = 4'b0110;
        pressed = 1'b1;
        wait_ticks(4);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h4) begin
            bad++;
            $display("FAIL prio_code got valid=%b code=%h exp valid=1 code=4",
                     key_valid, key_code);
        end
        total++;
        if (digit !== 16'h2344) begin
            bad++; $display("FAIL prio_digit got=%h exp=2344", digit);
        end
        wait_ticks(1);
        total++;
        if (key_held !== 1'b1) begin
            bad++; $display("FAIL prio_held got=%b exp=1", key_held);
        end
        rst     = 1'b1;
        pressed = 1'b0;
        @(negedge clk);
        total++;
        if (key_held !== 1'b0 || row !== 4'b1110) begin
            bad++;
            $display("FAIL midreset_state got held=%b row=%b exp held=0 row=1110",
                     key_held, row);
        end
        total++;
        if (digit !== 16'h0000 || key_code !== 4'h0 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_regs got digit=%h code=%h valid=%b exp 0000/0/0",
                     digit, key_code, key_valid);
        end
        rst = 1'b0;
        v1  = vcount;
        repeat (40) @(negedge clk);
        total++;
        if (vcount !== v1) begin
            bad++; $display("FAIL midreset_no_pulse got=%0d exp=%0d", vcount, v1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_single_press();
        test_bounce();
        test_sequence();
        test_priority_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad4x4_scan.md
# keypad4x4_scan

Scanner and debouncer for the board's 4x4 matrix keypad: the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad row low at a time, reads the four active-low columns, debounces a press over several scan periods, and emits one key code per press. Accepted codes are also shifted into a 16-bit nibble register, so the display driver can show the last four keys directly.

## Interface
- SCAN_DIV_BITS, 14, prescaler width; scan tick every 2^SCAN_DIV_BITS clk cycles (minimum 3)
- DEBOUNCE_SCANS, 4, consecutive matching ticks required to accept a press or a release (minimum 2)
- clk  in  1  system clock; the only clock
- rst  in  1  reset; synchronous, active-high
- col  in  4  keypad columns, active-low, asynchronous, pulled up externally
- row  out  4  keypad row drive, active-low, exactly one bit low
- key_code  out  4  last accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid  out  1  one-clk pulse when key_code is updated
- key_held  out  1  high from acceptance until release is debounced
- digit  out  16  last four codes, newest in [3:0], for the display driver

## Operation
- col passes through a 2-flop synchronizer; all decisions use the synchronized value (cs).
- Free-running prescaler; tick = prescaler at all-ones. row changes only on a tick.
- row_idx 0..3 maps to row 4'b1110, 4'b1101, 4'b1011, 4'b0111.
- Columns are sampled only on a tick, for the currently driven row.
- Multiple low columns: the lowest index wins. Other rows are ignored, so ghosting is not decoded.
- FSM states:
  - SCAN: on tick, if cs==4'hF, advance row_idx (3 wraps to 0). Otherwise latch col_idx, set cnt=0, and go to DEBOUNCE with row frozen.
  - DEBOUNCE: on tick, if cs[col_idx] is still low and col_idx is still the lowest low column, increment cnt. When cnt reaches DEBOUNCE_SCANS-1, go to PRESSED and accept the key. Any mismatch returns to SCAN and advances row_idx.
  - PRESSED: row stays frozen. On a tick with cs==4'hF, set cnt=0 and go to RELEASE.
  - RELEASE: on a tick with cs==4'hF, increment cnt; a tick with any column low resets cnt to 0. When cnt reaches DEBOUNCE_SCANS-1, go to SCAN and advance row_idx.
- Accepting a key does four things in the same clk:
  - key_code <= {row_idx, col_idx}
  - key_valid pulses
  - key_held goes high
  - digit <= {digit[11:0], key_code_new}
- A held key never auto-repeats. Only one key_valid is produced per press/release cycle.
- key_held is high in PRESSED and RELEASE, and low in SCAN and DEBOUNCE.
- digit is cleared only by rst; it wraps by shifting the oldest nibble out.

## Timing
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_held=0, digit=16'h0000. Also prescaler=0, state=SCAN, cnt=0, synchronizer=4'hF.
- rst in any state, including mid-DEBOUNCE or PRESSED, returns to the reset values on the next clk edge. No key_valid is emitted.
- All outputs are registered.
- Scan period per row: 2^SCAN_DIV_BITS clk. A full idle rotation takes 4·2^SCAN_DIV_BITS clk.
- Press latency: a press present on the detection tick T0 is accepted on tick T0+DEBOUNCE_SCANS-1 only if it matches on every intermediate tick. key_valid is high for the single clk following that tick.
- Release latency: DEBOUNCE_SCANS ticks, counted from the first all-high tick. Row scanning resumes on the tick that completes the release.
- Column-to-decision delay: 2 clk of synchronizer, always shorter than one scan period.

## Structure
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - ROW_DRIVE[0:3] constant (one-hot-low patterns)
  - function lowest_low(cs) returning the 2-bit index of the lowest low column
- Sub-module keypad_sync: parameterizable-width 2-flop synchronizer with reset value all-ones, instantiated on col.
- Prescaler, FSM, and digit shift register all live in keypad4x4_scan.

## Test plan
All scenarios use SCAN_DIV_BITS=3 and DEBOUNCE_SCANS=4, so one tick every 8 clk.
- **Reset:** assert rst 2 clk with col=4'hF -> row=4'b1110, key_code=0, key_valid=0, key_held=0, digit=16'h0000.
- **Idle scan:** col=4'hF for 40 clk -> row steps 1110→1101→1011→0111→1110, changing every 8 clk, with no key_valid.
- **Single press:** hold col=4'b1101 whenever row=4'b1011 (row2, col1), then release.
  - Exactly one key_valid pulse; key_code=4'h9; digit=16'h0009.
  - key_held is high and row stays frozen at 1011 until 4 all-high ticks have passed.
- **Bounce rejection:** column low for 2 ticks, then high -> no key_valid, key_held stays 0, and scanning resumes from the next row.
- **Sequence and no repeat:** press and release codes 1, 2, 3, 4, holding code 2 for 20 ticks.
  - Exactly 4 key_valid pulses.
  - digit=16'h1234.
- **Priority and reset mid-press:** on row1, col=4'b0110 -> key_code=4'h4. Then assert rst while in PRESSED -> key_held=0, row=4'b1110, digit=16'h0000, and no further pulse.
